// File: rtl/tap_controller_if.sv
// JTAG TAP pin bundle: serial data/mode pins toward the TAP and
// the boundary-scan control strobes it produces.
interface tap_controller_if;
    logic       TMS;
    logic       TDI;
    logic       bsr_tdo;
    logic       TDO;
    logic       TDO_en;
    logic       ShiftDR;
    logic       ClockDR;
    logic       UpdateDR;
    logic       Mode;
    logic [3:0] tap_state;

    modport master (
        output TMS, TDI, bsr_tdo,
        input  TDO, TDO_en, ShiftDR, ClockDR, UpdateDR, Mode, tap_state
    );

    modport slave (
        input  TMS, TDI, bsr_tdo,
        output TDO, TDO_en, ShiftDR, ClockDR, UpdateDR, Mode, tap_state
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 2-bit IR (EXTEST, SAMPLE/PRELOAD, BYPASS),
// bypass register and boundary-scan cell control strobes.
module tap_controller (
    input  logic            TCK,
    input  logic            Reset,
    tap_controller_if.slave bus
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e state_q, state_d;
    logic [1:0] ir_sr_q, ir_sr_d;
    logic [1:0] ir_q, ir_d;
    logic       bypass_q, bypass_d;
    logic       shift_dr_q, shift_dr_d;
    logic       ck_en_q, ck_en_d;
    logic       upd_q, upd_d;
    logic       tdo_q, tdo_d;
    logic       tdo_en_q, tdo_en_d;
    logic       ir_is_bypass;

    // Codes 10 and 11 both select BYPASS, so the MSB alone decides it.
    assign ir_is_bypass = ir_q[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = bus.TMS ? TLR    : RTI;
            RTI:    state_d = bus.TMS ? SEL_DR : RTI;
            SEL_DR: state_d = bus.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = bus.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = bus.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = bus.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = bus.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = bus.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = bus.TMS ? SEL_DR : RTI;
            SEL_IR: state_d = bus.TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = bus.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = bus.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = bus.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = bus.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = bus.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = bus.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_sr_d = ir_sr_q;
        if (state_q == CAP_IR)
            ir_sr_d = 2'b01;
        else if (state_q == SH_IR)
            ir_sr_d = {bus.TDI, ir_sr_q[1]};

        bypass_d = bypass_q;
        if (state_q == CAP_DR)
            bypass_d = 1'b0;
        else if (state_q == SH_DR)
            bypass_d = bus.TDI;

        // Decoding the next state keeps ShiftDR a flop that tracks tap_state exactly.
        shift_dr_d = (state_d == SH_DR);
    end

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            state_q    <= TLR;
            ir_sr_q    <= 2'b01;
            bypass_q   <= 1'b0;
            shift_dr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_sr_q    <= ir_sr_d;
            bypass_q   <= bypass_d;
            shift_dr_q <= shift_dr_d;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (state_q == UPD_IR)
            ir_d = ir_sr_q;
        else if (state_q == TLR)
            ir_d = 2'b11;

        ck_en_d  = ((state_q == CAP_DR) || (state_q == SH_DR)) && !ir_is_bypass;
        upd_d    = (state_q == UPD_DR) && !ir_is_bypass;
        tdo_en_d = (state_q == SH_IR) || (state_q == SH_DR);

        tdo_d = 1'b0;
        if (state_q == SH_IR)
            tdo_d = ir_sr_q[0];
        else if (state_q == SH_DR)
            tdo_d = ir_is_bypass ? bypass_q : bus.bsr_tdo;
    end

    // Falling-edge stage: the enable only changes while TCK is low,
    // so TCK & ck_en_q cannot glitch.
    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            ir_q     <= 2'b11;
            ck_en_q  <= 1'b0;
            upd_q    <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ck_en_q  <= ck_en_d;
            upd_q    <= upd_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign bus.tap_state = state_q;
    assign bus.ShiftDR   = shift_dr_q;
    assign bus.ClockDR   = TCK & ck_en_q;
    assign bus.UpdateDR  = upd_q;
    assign bus.Mode      = (ir_q == 2'b00);
    assign bus.TDO       = tdo_q;
    assign bus.TDO_en    = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// Directed vector table plus reset and random-TMS sequences for tap_controller.
module tb_tap_controller;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic       bsr;
        logic [3:0] st;
        logic       tdo;
        logic       en;
        logic       sdr;
        logic       upd;
        logic       mode;
        int         ck;
        int         up;
    } vec_t;

    logic TCK;
    logic Reset;
    tap_controller_if bus ();

    tap_controller dut (
        .TCK   (TCK),
        .Reset (Reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   ck_cnt = 0;
    int   up_cnt = 0;
    vec_t vecs[$];

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    always @(posedge bus.ClockDR) ck_cnt++;
    always @(posedge bus.UpdateDR) up_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic tms, input logic tdi, input logic bsr, input logic [3:0] st,
                       input logic tdo, input logic en, input logic sdr, input logic upd,
                       input logic mode, input int ck, input int up);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.bsr = bsr; v.st = st; v.tdo = tdo; v.en = en;
        v.sdr = sdr; v.upd = upd; v.mode = mode; v.ck = ck; v.up = up;
        vecs.push_back(v);
    endtask

    // Called while TCK is low; returns 1 time unit after the following fall.
    task automatic step(input logic tms, input logic tdi, input logic bsr);
        bus.TMS = tms;
        bus.TDI = tdi;
        bus.bsr_tdo = bsr;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic run_vec(input int i);
        step(vecs[i].tms, vecs[i].tdi, vecs[i].bsr);
        chk("tap_state", i, 32'(bus.tap_state), 32'(vecs[i].st));
        chk("TDO",       i, 32'(bus.TDO),       32'(vecs[i].tdo));
        chk("TDO_en",    i, 32'(bus.TDO_en),    32'(vecs[i].en));
        chk("ShiftDR",   i, 32'(bus.ShiftDR),   32'(vecs[i].sdr));
        chk("UpdateDR",  i, 32'(bus.UpdateDR),  32'(vecs[i].upd));
        chk("Mode",      i, 32'(bus.Mode),      32'(vecs[i].mode));
        chk("ClockDR_rises",  i, 32'(ck_cnt),   32'(vecs[i].ck));
        chk("UpdateDR_rises", i, 32'(up_cnt),   32'(vecs[i].up));
    endtask

    task automatic chk_reset_outputs(input int tag);
        chk("rst_tap_state", tag, 32'(bus.tap_state), 32'hF);
        chk("rst_TDO",       tag, 32'(bus.TDO),       32'h0);
        chk("rst_TDO_en",    tag, 32'(bus.TDO_en),    32'h0);
        chk("rst_ShiftDR",   tag, 32'(bus.ShiftDR),   32'h0);
        chk("rst_ClockDR",   tag, 32'(bus.ClockDR),   32'h0);
        chk("rst_UpdateDR",  tag, 32'(bus.UpdateDR),  32'h0);
        chk("rst_Mode",      tag, 32'(bus.Mode),      32'h0);
    endtask

    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic tms);
        case (s)
            4'hF: ref_next = tms ? 4'hF : 4'hC;
            4'hC: ref_next = tms ? 4'h7 : 4'hC;
            4'h7: ref_next = tms ? 4'h4 : 4'h6;
            4'h6: ref_next = tms ? 4'h1 : 4'h2;
            4'h2: ref_next = tms ? 4'h1 : 4'h2;
            4'h1: ref_next = tms ? 4'h5 : 4'h3;
            4'h3: ref_next = tms ? 4'h0 : 4'h3;
            4'h0: ref_next = tms ? 4'h5 : 4'h2;
            4'h5: ref_next = tms ? 4'h7 : 4'hC;
            4'h4: ref_next = tms ? 4'hF : 4'hE;
            4'hE: ref_next = tms ? 4'h9 : 4'hA;
            4'hA: ref_next = tms ? 4'h9 : 4'hA;
            4'h9: ref_next = tms ? 4'hD : 4'hB;
            4'hB: ref_next = tms ? 4'h8 : 4'hB;
            4'h8: ref_next = tms ? 4'hD : 4'hA;
            default: ref_next = tms ? 4'h7 : 4'hC;
        endcase
    endfunction

    initial begin
        logic [3:0] model_st;
        logic       r_tms;

        //  tms tdi bsr st    tdo en sdr upd mode ck up
        // Load EXTEST through the IR
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4'h7, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4'h4, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'hA, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 4'hA, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4'h9, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 4'hD, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 1, 0, 0);
        // EXTEST DR scan of three cells
        add(1, 0, 0, 4'h7, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 4'h6, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'h2, 1, 1, 1, 0, 1, 1, 0);
        add(0, 0, 0, 4'h2, 0, 1, 1, 0, 1, 2, 0);
        add(0, 0, 1, 4'h2, 1, 1, 1, 0, 1, 3, 0);
        add(1, 0, 0, 4'h1, 0, 0, 0, 0, 1, 4, 0);
        add(1, 0, 0, 4'h5, 0, 0, 0, 1, 1, 4, 1);
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 1, 4, 1);
        // Pause and resume inside a DR scan
        add(1, 0, 0, 4'h7, 0, 0, 0, 0, 1, 4, 1);
        add(0, 0, 0, 4'h6, 0, 0, 0, 0, 1, 4, 1);
        add(0, 0, 1, 4'h2, 1, 1, 1, 0, 1, 5, 1);
        add(1, 0, 1, 4'h1, 0, 0, 0, 0, 1, 6, 1);
        add(0, 0, 1, 4'h3, 0, 0, 0, 0, 1, 6, 1);
        add(0, 0, 1, 4'h3, 0, 0, 0, 0, 1, 6, 1);
        add(0, 0, 1, 4'h3, 0, 0, 0, 0, 1, 6, 1);
        add(1, 0, 1, 4'h0, 0, 0, 0, 0, 1, 6, 1);
        add(0, 0, 1, 4'h2, 1, 1, 1, 0, 1, 6, 1);
        add(1, 0, 0, 4'h1, 0, 0, 0, 0, 1, 7, 1);
        add(1, 0, 0, 4'h5, 0, 0, 0, 1, 1, 7, 2);
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 1, 7, 2);
        // Enter ShDR again; reset is pulsed there
        add(1, 0, 0, 4'h7, 0, 0, 0, 0, 1, 7, 2);
        add(0, 0, 0, 4'h6, 0, 0, 0, 0, 1, 7, 2);
        add(0, 0, 1, 4'h2, 1, 1, 1, 0, 1, 8, 2);
        // After reset: TMS=1 walk stays in TLR, then TMS=0 leaves it
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'hF, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 0, 8, 2);
        // Load IR=10 (BYPASS)
        add(1, 0, 0, 4'h7, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'h4, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 0, 4'hE, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 0, 4'hA, 1, 1, 0, 0, 0, 8, 2);
        add(0, 0, 0, 4'hA, 0, 1, 0, 0, 0, 8, 2);
        add(1, 1, 0, 4'h9, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 0, 4'hD, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 0, 4'hC, 0, 0, 0, 0, 0, 8, 2);
        // BYPASS DR scan, bsr_tdo held high so it must not appear on TDO
        add(1, 0, 1, 4'h7, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 1, 4'h6, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 1, 4'h2, 0, 1, 1, 0, 0, 8, 2);
        add(0, 1, 1, 4'h2, 1, 1, 1, 0, 0, 8, 2);
        add(0, 0, 1, 4'h2, 0, 1, 1, 0, 0, 8, 2);
        add(1, 1, 1, 4'h1, 0, 0, 0, 0, 0, 8, 2);
        add(1, 0, 1, 4'h5, 0, 0, 0, 0, 0, 8, 2);
        add(0, 0, 1, 4'hC, 0, 0, 0, 0, 0, 8, 2);

        bus.TMS = 1'b0;
        bus.TDI = 1'b0;
        bus.bsr_tdo = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge TCK);
        @(posedge TCK);
        #1;
        chk_reset_outputs(0);
        @(negedge TCK);
        #1;
        chk_reset_outputs(1);
        Reset = 1'b0;
        ck_cnt = 0;
        up_cnt = 0;

        for (int i = 0; i < 32; i++) run_vec(i);

        // Asynchronous reset in the low phase of ShDR, no TCK edge in between
        Reset = 1'b1;
        #1;
        chk_reset_outputs(2);
        @(posedge TCK);
        #1;
        chk_reset_outputs(3);
        @(negedge TCK);
        #1;
        Reset = 1'b0;
        chk("rst_ClockDR_rises", 4, 32'(ck_cnt), 32'd8);
        chk("rst_UpdateDR_rises", 4, 32'(up_cnt), 32'd2);

        for (int i = 32; i < vecs.size(); i++) run_vec(i);

        model_st = 4'hC;
        for (int n = 0; n < 1000; n++) begin
            r_tms = 1'($urandom_range(0, 1));
            model_st = ref_next(model_st, r_tms);
            step(r_tms, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("rand_tap_state", n, 32'(bus.tap_state), 32'(model_st));
            chk("rand_ShiftDR", n, 32'(bus.ShiftDR), 32'(model_st == 4'h2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
